// File: rtl/uart_dds_pkg.sv
// uart_dds_pkg: shared types and constants for the UART command path of the DDS controller.
package uart_dds_pkg;
    localparam int         CFG_ADDR_W    = 4;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_DATA, ST_CHK, ST_WRITE, ST_FLUSH
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_PARITY  = 3'd1,
        ERR_FRAME   = 3'd2,
        ERR_CHKSUM  = 3'd3,
        ERR_TIMEOUT = 3'd4,
        ERR_OVERRUN = 3'd5,
        ERR_ADDR    = 3'd6
    } err_e;

    // Line errors outrank any packet-level error found on the same byte.
    function automatic err_e line_err(input logic par, input logic frm);
        return par ? ERR_PARITY : frm ? ERR_FRAME : ERR_NONE;
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider giving a 1-cycle baud_tick every CLK_DIV clocks.
module uart_baud_gen #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    output logic baud_tick
);
    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign baud_tick = (cnt_q == LAST);
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses SYNC/ADDR/D3..D0[/CHK] byte packets into config-bank writes.
// Define UART_CMD_CHKSUM_EN for the 7-byte packet with trailing XOR checksum.
module uart_cmd_ctrl
    import uart_dds_pkg::*;
#(
    parameter int         CLK_DIV     = 27,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 20000,
    parameter int         FLUSH_TICKS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rx_par_err,
    input  logic                  rx_frm_err,
    input  logic                  cfg_ack,
    output logic                  baud_tick,
    output logic                  enable_rx,
    output logic                  cfg_wr,
    output logic [CFG_ADDR_W-1:0] cfg_addr,
    output logic [31:0]           cfg_data,
    output logic                  err_pulse,
    output logic [2:0]            err_code,
    output logic                  busy
);
    localparam int            TW         = $clog2(TIMEOUT_CYC);
    localparam int            FW         = $clog2(FLUSH_TICKS);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_TICKS - 1);

    state_e                  state_q, state_d;
    logic [CFG_ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic [7:0]              acc_q, acc_d;
    logic [1:0]              idx_q, idx_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [FW-1:0]           flush_q, flush_d;
    logic                    en_q, en_d;
    logic                    err_pulse_q, err_pulse_d;
    err_e                    err_code_q, err_code_d;
    err_e                    byte_code, fail_code;
    logic                    fail, rx_ok, start, in_pkt;

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick)
    );

    assign byte_code = line_err(rx_par_err, rx_frm_err);
    assign rx_ok     = rx_valid && (byte_code == ERR_NONE);
    assign start     = rx_ok && (rx_data == SYNC_BYTE);
    assign in_pkt    = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_CHK);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        flush_d   = flush_q;
        fail      = 1'b0;
        fail_code = ERR_NONE;
        tmo_d     = (rx_valid || !in_pkt) ? '0 : tmo_q + 1'b1;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_ADDR;
            ST_ADDR: if (rx_ok) begin
                if (rx_data[7:CFG_ADDR_W] != '0) begin
                    fail      = 1'b1;
                    fail_code = ERR_ADDR;
                end else begin
                    addr_d  = rx_data[CFG_ADDR_W-1:0];
                    acc_d   = rx_data;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: if (rx_ok) begin
                data_d = {data_q[23:0], rx_data};
                acc_d  = acc_q ^ rx_data;
                idx_d  = idx_q + 1'b1;
`ifdef UART_CMD_CHKSUM_EN
                if (idx_q == 2'd3) state_d = ST_CHK;
`else
                if (idx_q == 2'd3) state_d = ST_WRITE;
`endif
            end
            ST_CHK: if (rx_ok) begin
                if (rx_data == acc_q) state_d = ST_WRITE;
                else begin
                    fail      = 1'b1;
                    fail_code = ERR_CHKSUM;
                end
            end
            // A byte arriving with the ack belongs to the next packet, not an overrun.
            ST_WRITE: if (cfg_ack) state_d = start ? ST_ADDR : ST_IDLE;
                else if (rx_ok) begin
                    fail      = 1'b1;
                    fail_code = ERR_OVERRUN;
                end
            ST_FLUSH: if (baud_tick) begin
                if (flush_q == FLUSH_LAST) state_d = ST_IDLE;
                else flush_d = flush_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rx_valid && byte_code != ERR_NONE && (in_pkt || (state_q == ST_WRITE && !cfg_ack))) begin
            fail      = 1'b1;
            fail_code = byte_code;
        end
        if (in_pkt && !rx_valid && tmo_q == TMO_LAST) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
        end
        if (fail) begin
            state_d = ST_FLUSH;
            flush_d = '0;
        end
        en_d        = (state_d != ST_FLUSH);
        err_pulse_d = fail;
        err_code_d  = fail ? fail_code : err_code_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            flush_q     <= '0;
            en_q        <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            flush_q     <= flush_d;
            en_q        <= en_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
        end

    assign enable_rx = en_q;
    assign cfg_wr    = (state_q == ST_WRITE);
    assign cfg_addr  = addr_q;
    assign cfg_data  = data_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed and randomized checks of uart_cmd_ctrl against a packet-level model.
// Honours UART_CMD_CHKSUM_EN the same way as the design.
module tb_uart_cmd_ctrl;
    localparam int CLK_DIV     = 27;
    localparam int TIMEOUT_CYC = 20000;
    localparam int FLUSH_TICKS = 16;
`ifdef UART_CMD_CHKSUM_EN
    localparam int PKT_LEN = 7;
`else
    localparam int PKT_LEN = 6;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        rx_valid = 1'b0, rx_par_err = 1'b0, rx_frm_err = 1'b0, cfg_ack = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        baud_tick, enable_rx, cfg_wr, err_pulse, busy;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [2:0]  err_code;

    int errors = 0, checks = 0;
    int pulses = 0, wr_cnt = 0;

    uart_cmd_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_par_err (rx_par_err),
        .rx_frm_err (rx_frm_err),
        .cfg_ack    (cfg_ack),
        .baud_tick  (baud_tick),
        .enable_rx  (enable_rx),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_pulse) pulses++;
        if (cfg_wr) wr_cnt++;
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: simulation still running after 200000 cycles");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] chk_of(input logic [7:0] a, input logic [31:0] d);
        return a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic par, input logic frm);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = b; rx_par_err = par; rx_frm_err = frm;
        @(negedge clk);
        rx_valid = 1'b0; rx_par_err = 1'b0; rx_frm_err = 1'b0;
    endtask

    task automatic send_body(input logic [7:0] a, input logic [31:0] d);
        send_byte(8'hA5, 0, 0);
        send_byte(a, 0, 0);
        for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 0, 0);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(chk_of(a, d), 0, 0);
`endif
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle: busy=%b expected 0", tag, busy); end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({baud_tick, enable_rx, cfg_wr, cfg_addr, cfg_data, err_pulse, err_code, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: tick=%b en=%b wr=%b addr=%h data=%h pulse=%b code=%0d busy=%b expected all 0",
                     baud_tick, enable_rx, cfg_wr, cfg_addr, cfg_data, err_pulse, err_code, busy);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (enable_rx !== 1'b0) begin errors++; $display("FAIL reset_en_before_clk: enable_rx=%b expected 0", enable_rx); end
        @(negedge clk);
        checks++;
        if (enable_rx !== 1'b1) begin errors++; $display("FAIL reset_en_after_clk: enable_rx=%b expected 1", enable_rx); end
    endtask

    task automatic test_baud;
        int n = 0, period = 0;
        while (!baud_tick && n < 100) begin @(negedge clk); n++; end
        do begin @(negedge clk); period++; end while (!baud_tick && period < 100);
        checks++;
        if (period != CLK_DIV) begin errors++; $display("FAIL baud_period: period=%0d expected %0d", period, CLK_DIV); end
    endtask

    task automatic test_idle_ignore;
        int p0 = pulses;
        send_byte(8'h55, 0, 0);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_ignore_busy: busy=%b expected 0", busy); end
        send_byte(8'h3C, 1, 1);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pulses != p0) begin
            errors++; $display("FAIL idle_ignore_err: busy=%b pulses=%0d expected 0 and %0d", busy, pulses, p0);
        end
    endtask

    task automatic test_write;
        int w0 = wr_cnt, p0 = pulses;
        send_body(8'h03, 32'h12345678);
        checks++;
        if (cfg_wr !== 1'b1 || cfg_addr !== 4'h3 || cfg_data !== 32'h12345678) begin
            errors++; $display("FAIL write_req: wr=%b addr=%h data=%h expected 1 3 12345678", cfg_wr, cfg_addr, cfg_data);
        end
        @(negedge clk); cfg_ack = 1'b1;
        @(negedge clk); cfg_ack = 1'b0;
        checks++;
        if (cfg_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL write_drop: wr=%b busy=%b expected 0 0", cfg_wr, busy); end
        @(negedge clk);
        checks++;
        if (wr_cnt - w0 != 2 || pulses != p0) begin
            errors++; $display("FAIL write_len: wr_cycles=%0d pulses=%0d expected 2 0", wr_cnt - w0, pulses - p0);
        end
        checks++;
        if (cfg_addr !== 4'h3 || cfg_data !== 32'h12345678) begin
            errors++; $display("FAIL write_hold: addr=%h data=%h expected 3 12345678", cfg_addr, cfg_data);
        end
    endtask

`ifdef UART_CMD_CHKSUM_EN
    task automatic test_checksum;
        int w0 = wr_cnt, t = 0, n = 0;
        send_byte(8'hA5, 0, 0);
        send_byte(8'h03, 0, 0);
        send_byte(8'h12, 0, 0);
        send_byte(8'h34, 0, 0);
        send_byte(8'h56, 0, 0);
        send_byte(8'h78, 0, 0);
        send_byte(8'h00, 0, 0);
        checks++;
        if (err_pulse !== 1'b1 || err_code !== 3'd3) begin
            errors++; $display("FAIL chk_err: pulse=%b code=%0d expected 1 3", err_pulse, err_code);
        end
        while (!enable_rx && n < 1000) begin
            if (baud_tick) t++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (t != FLUSH_TICKS || wr_cnt != w0) begin
            errors++; $display("FAIL chk_flush: ticks=%0d writes=%0d expected %0d 0", t, wr_cnt - w0, FLUSH_TICKS);
        end
    endtask
`endif

    task automatic test_timeout;
        int n = 0;
        send_byte(8'hA5, 0, 0);
        send_byte(8'h03, 0, 0);
        send_byte(8'h12, 0, 0);
        while (!err_pulse && n < TIMEOUT_CYC + 20) begin @(negedge clk); n++; end
        checks++;
        if (n != TIMEOUT_CYC || err_code !== 3'd4) begin
            errors++; $display("FAIL timeout: cycles=%0d code=%0d expected %0d 4", n, err_code, TIMEOUT_CYC);
        end
        wait_idle("timeout");
    endtask

    task automatic test_bad_addr;
        int w0 = wr_cnt, p0 = pulses, t = 0, n = 0;
        send_byte(8'hA5, 0, 0);
        send_byte(8'h13, 0, 0);
        checks++;
        if (err_pulse !== 1'b1 || err_code !== 3'd6 || enable_rx !== 1'b0) begin
            errors++; $display("FAIL bad_addr: pulse=%b code=%0d en=%b expected 1 6 0", err_pulse, err_code, enable_rx);
        end
        while (!enable_rx && n < 1000) begin
            if (baud_tick) t++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (t != FLUSH_TICKS || busy !== 1'b0) begin
            errors++; $display("FAIL flush_ticks: ticks=%0d busy=%b expected %0d 0", t, busy, FLUSH_TICKS);
        end
        checks++;
        if (wr_cnt != w0 || pulses - p0 != 1) begin
            errors++; $display("FAIL bad_addr_side: writes=%0d pulses=%0d expected 0 1", wr_cnt - w0, pulses - p0);
        end
    endtask

    task automatic test_parity;
        int w0 = wr_cnt, p0 = pulses;
        send_byte(8'hA5, 0, 0);
        send_byte(8'h03, 0, 0);
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        send_byte(8'h33, 1, 1);
        checks++;
        if (err_code !== 3'd1) begin errors++; $display("FAIL parity_code: code=%0d expected 1", err_code); end
        send_byte(8'h44, 0, 0);
        send_byte(8'hA5, 0, 0);
        wait_idle("parity");
        checks++;
        if (wr_cnt != w0 || pulses - p0 != 1) begin
            errors++; $display("FAIL parity_side: writes=%0d pulses=%0d expected 0 1", wr_cnt - w0, pulses - p0);
        end
    endtask

    task automatic test_overrun;
        send_body(8'h05, 32'hCAFEF00D);
        checks++;
        if (cfg_wr !== 1'b1) begin errors++; $display("FAIL overrun_pre: cfg_wr=%b expected 1", cfg_wr); end
        send_byte(8'h55, 0, 0);
        checks++;
        if (err_code !== 3'd5 || cfg_wr !== 1'b0 || err_pulse !== 1'b1) begin
            errors++; $display("FAIL overrun: code=%0d wr=%b pulse=%b expected 5 0 1", err_code, cfg_wr, err_pulse);
        end
        wait_idle("overrun");
    endtask

    task automatic test_reset_mid_data;
        send_byte(8'hA5, 0, 0);
        send_byte(8'h03, 0, 0);
        send_byte(8'h12, 0, 0);
        @(negedge clk); rst_n = 1'b0;
        #1;
        checks++;
        if (cfg_wr !== 1'b0 || busy !== 1'b0 || err_code !== 3'd0 || enable_rx !== 1'b0) begin
            errors++; $display("FAIL rst_mid_data: wr=%b busy=%b code=%0d en=%b expected 0 0 0 0", cfg_wr, busy, err_code, enable_rx);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        send_body(8'h0A, 32'hDEADBEEF);
        checks++;
        if (cfg_wr !== 1'b1 || cfg_addr !== 4'hA || cfg_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rst_recover: wr=%b addr=%h data=%h expected 1 a deadbeef", cfg_wr, cfg_addr, cfg_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (cfg_wr !== 1'b0) begin errors++; $display("FAIL rst_in_write: cfg_wr=%b expected 0", cfg_wr); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int p0 = pulses;
        send_body(8'h01, 32'h11111111);
        checks++;
        if (cfg_wr !== 1'b1 || cfg_data !== 32'h11111111) begin
            errors++; $display("FAIL b2b_first: wr=%b data=%h expected 1 11111111", cfg_wr, cfg_data);
        end
        cfg_ack = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
        @(negedge clk);
        cfg_ack = 1'b0; rx_valid = 1'b0;
        send_byte(8'h02, 0, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h22, 0, 0);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(chk_of(8'h02, 32'h22222222), 0, 0);
`endif
        checks++;
        if (cfg_wr !== 1'b1 || cfg_addr !== 4'h2 || cfg_data !== 32'h22222222 || pulses != p0) begin
            errors++; $display("FAIL b2b_second: wr=%b addr=%h data=%h pulses=%0d expected 1 2 22222222 0",
                               cfg_wr, cfg_addr, cfg_data, pulses - p0);
        end
        cfg_ack = 1'b1;
        @(negedge clk); cfg_ack = 1'b0;
        wait_idle("b2b");
    endtask

    task automatic test_random;
        logic [7:0]  pkt [0:6];
        logic [31:0] d;
        logic [3:0]  a;
        logic        par, frm;
        int          kind, kmax, fi, last, exp_code, p0, w0;
`ifdef UART_CMD_CHKSUM_EN
        kmax = 4;
`else
        kmax = 3;
`endif
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, kmax);
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            pkt[0] = 8'hA5; pkt[1] = {4'h0, a};
            for (int i = 0; i < 4; i++) pkt[2 + i] = d[8*(3 - i) +: 8];
            pkt[6] = chk_of(pkt[1], d);
            last = PKT_LEN - 1; fi = -1; par = 1'b0; frm = 1'b0; exp_code = 0;
            case (kind)
                1: begin pkt[1][7:4] = 4'($urandom_range(1, 15)); last = 1; exp_code = 6; end
                2: begin
                    fi = $urandom_range(1, PKT_LEN - 1); last = fi;
                    par = 1'($urandom_range(0, 1));
                    frm = par ? 1'($urandom_range(0, 1)) : 1'b1;
                    exp_code = par ? 1 : 2;
                end
                3: exp_code = 5;
                4: begin pkt[6] = pkt[6] ^ 8'($urandom_range(1, 255)); exp_code = 3; end
                default: exp_code = 0;
            endcase
            p0 = pulses; w0 = wr_cnt;
            for (int i = 0; i <= last; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send_byte(pkt[i], (i == fi) ? par : 1'b0, (i == fi) ? frm : 1'b0);
            end
            if (kind == 0 || kind == 3) begin
                checks++;
                if (cfg_wr !== 1'b1 || cfg_addr !== a || cfg_data !== d) begin
                    errors++; $display("FAIL rand_write[%0d]: wr=%b addr=%h data=%h expected 1 %h %h", it, cfg_wr, cfg_addr, cfg_data, a, d);
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if (kind == 0) begin
                    cfg_ack = 1'b1;
                    @(negedge clk); cfg_ack = 1'b0;
                end else begin
                    send_byte(8'($urandom), 0, 0);
                end
            end
            checks++;
            if (kind != 0 && (err_pulse !== 1'b1 || err_code !== 3'(exp_code))) begin
                errors++; $display("FAIL rand_err[%0d]: pulse=%b code=%0d expected 1 %0d", it, err_pulse, err_code, exp_code);
            end else if (kind == 0 && cfg_wr !== 1'b0) begin
                errors++; $display("FAIL rand_ack[%0d]: cfg_wr=%b expected 0", it, cfg_wr);
            end
            @(negedge clk);
            checks++;
            if (pulses - p0 != (kind != 0 ? 1 : 0) || (kind != 0 && kind != 3 && wr_cnt != w0)) begin
                errors++; $display("FAIL rand_side[%0d]: pulses=%0d writes=%0d kind=%0d", it, pulses - p0, wr_cnt - w0, kind);
            end
            wait_idle("rand");
        end
    endtask

    initial begin
        test_reset;
        test_baud;
        test_idle_ignore;
        test_write;
`ifdef UART_CMD_CHKSUM_EN
        test_checksum;
`endif
        test_timeout;
        test_bad_addr;
        test_parity;
        test_overrun;
        test_reset_mid_data;
        test_back_to_back;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
